edge_event_arbiter: RTL
=======================

Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller. Runs one Moore-style level-to-pulse edge detector per input channel and latches each detected rising edge as a pending event.
- Pending events are scheduled round-robin onto a single valid/ready event port that feeds the downstream interrupt/event consumer.
- Sits between raw synchronized level inputs and the shared event sink. Provides per-channel masking and per-channel sticky overflow reporting.

Parameters:
- N_CH, 4, number of level input channels (2..16).
- ID_W, 2, width of evt_id; must satisfy 2**ID_W >= N_CH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- level  input  N_CH  synchronized level inputs, one per channel.
- ch_en  input  N_CH  per-channel enable; 0 = detector held in ZERO, pending cleared, no new events.
- evt_valid  output  1  event available on evt_id.
- evt_ready  input  1  consumer accepts event when evt_valid & evt_ready.
- evt_id  output  ID_W  channel index of the presented event.
- pending  output  N_CH  pending-event bit per channel (registered).
- ovf  output  N_CH  sticky overflow per channel: an edge arrived while that channel was already pending.
- ovf_clr  input  N_CH  write-1-to-clear for ovf bits.

Behaviour:
- Reset (reset=1 at a clk edge):
  - All detectors go to ZERO.
  - pending=0, ovf=0, evt_valid=0, evt_id=0.
  - RR pointer=0.
  - Reset has priority over every other event. Asserting it mid-handshake drops the in-flight event without acceptance.
- Per-channel detector (3 states; output is a function of state only):
  - ZERO: level=1 -> SPIKE, else stay ZERO.
  - SPIKE: level=1 -> ONE, level=0 -> ZERO. Detector pulse det[i]=1 only while in SPIKE.
  - ONE: level=1 -> stay ONE, level=0 -> ZERO.
  - ch_en[i]=0 forces the next state to ZERO and det[i] is ignored.
- Pending set/clear per channel, evaluated each cycle:
  - set = det[i] & ch_en[i].
  - clr = grant taken on channel i this cycle (evt_valid & evt_ready & evt_id==i), or ch_en[i]=0.
  - set & clr in the same cycle from acceptance: pending stays 1 (new event kept), ovf not set.
  - set while pending[i]=1 and not being cleared: pending stays 1, ovf[i] <= 1.
  - ovf_clr[i] & new overflow in the same cycle: ovf[i] stays 1 (set wins).
- Latency:
  - level first sampled 1 at edge k -> SPIKE after k -> pending after k+1 -> evt_valid after k+2 if the output stage is empty.
  - Minimum latency is 2 cycles from the sampling edge to visible evt_valid.
- Output stage (one-entry register):
  - If empty, or being accepted this cycle, and any pending bit is not currently held in the output, load the winner: evt_valid<=1, evt_id<=winner.
  - Otherwise evt_valid<=0 when accepted.
  - evt_id stays stable while evt_valid=1 and evt_ready=0.
  - A channel already held in the output register is excluded from the search.
  - Back-to-back acceptance gives one event per cycle.
- Round-robin:
  - Search starts at the RR pointer and wraps modulo N_CH.
  - After each load, pointer <= winner+1; N_CH-1 wraps to 0.
  - Pointer is unchanged when nothing is loaded.
- Masking:
  - Clearing ch_en[i] while channel i is held in the output register does not retract it; the event completes normally.
- Reset values summary: evt_valid=0, evt_id=0, pending=0, ovf=0.

Optional Feature:
- Macro EDGE_EVT_FALL_EN.
- When defined:
  - Adds output evt_fall (1 bit).
  - Each detector also recognises falling edges via two extra states: ONE with level=0 -> FSPIKE; FSPIKE with level=0 -> ZERO, with level=1 -> SPIKE.
  - FSPIKE produces a falling pulse. pending is split into rise and fall bits; pending output is their OR.
  - Priority within a channel: rise before fall. evt_fall=1 marks a falling event. ovf applies to each kind independently and reports to the same bit.
- When undefined:
  - 3-state detector only, rising edges only, no evt_fall port.

Test Plan:
- Reset: hold reset 3 cycles with level=4'hF -> evt_valid=0, pending=0, ovf=0. Release with level steady 4'hF -> first event on ch0 appears 2 cycles later.
- Single edge: ch_en=4'hF, evt_ready=1, level[2] 0->1 sampled at edge k -> evt_valid=1, evt_id=2 after k+2 for exactly 1 cycle. No further events while level[2] stays 1.
- Round-robin: simultaneous rising edges on ch0,1,3 with evt_ready=1 -> evt_id sequence 0,1,3 on consecutive cycles. Repeat the edges -> order 0,1,3 again (pointer wrap).
- Backpressure/overflow: evt_ready=0, ch1 edge at t -> evt_id=1 held. Second ch1 edge while pending (level 1,0,1) -> ovf[1]=1. ovf_clr[1]=1 -> ovf[1]=0 next cycle.
- Simultaneous accept+set: ch0 pending, and its accept coincides with a new ch0 det pulse -> pending[0] remains 1, ovf[0]=0, a second ch0 event is delivered.
- Mask/reset mid-op: ch_en[3]=0 with pending[3]=1 -> pending[3]=0 next cycle, no event. reset asserted while evt_valid=1, evt_ready=0 -> evt_valid=0 next cycle.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel level-to-pulse detectors feed
// pending bits that are scheduled round-robin onto one valid/ready event port.
// Optional falling-edge events are enabled by defining EDGE_EVT_FALL_EN.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] level,
    input  logic [N_CH-1:0] ch_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
`ifdef EDGE_EVT_FALL_EN
    output logic            evt_fall,
`endif
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    typedef enum logic [1:0] {
        ST_ZERO   = 2'd0,
        ST_SPIKE  = 2'd1,
        ST_ONE    = 2'd2,
        ST_FSPIKE = 2'd3
    } det_state_e;

    localparam logic [ID_W-1:0] LAST_CH = ID_W'(N_CH - 1);

    det_state_e      state_r      [N_CH];
    det_state_e      state_next_s [N_CH];
    logic [N_CH-1:0] rise_det_s;
    logic [N_CH-1:0] set_rise_s;
    logic [N_CH-1:0] take_s;
    logic [N_CH-1:0] take_rise_s;
    logic [N_CH-1:0] held_s;
    logic [N_CH-1:0] cand_s;
    logic [N_CH-1:0] pend_any_s;
    logic [N_CH-1:0] pend_rise_r;
    logic [N_CH-1:0] pend_rise_next_s;
    logic [N_CH-1:0] ovf_r;
    logic [N_CH-1:0] ovf_next_s;
    logic            evt_valid_r;
    logic [ID_W-1:0] evt_id_r;
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] winner_s;
    logic            found_s;
    logic            accept_s;
    logic            load_s;
`ifdef EDGE_EVT_FALL_EN
    logic [N_CH-1:0] fall_det_s;
    logic [N_CH-1:0] set_fall_s;
    logic [N_CH-1:0] take_fall_s;
    logic [N_CH-1:0] pend_fall_r;
    logic [N_CH-1:0] pend_fall_next_s;
    logic            evt_fall_r;
`endif

    // Channel index reached k steps after ptr, wrapping modulo N_CH.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= N_CH) begin
            s = s - N_CH;
        end else begin
            s = s;
        end
        return ID_W'(s);
    endfunction

    // Detector state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (reset) begin
                state_r[i] <= ST_ZERO;
            end else begin
                state_r[i] <= state_next_s[i];
            end
        end
    end

    // Detector next-state; a disabled channel is parked in ZERO.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_next_s[i] = ST_ZERO;
            if (!ch_en[i]) begin
                state_next_s[i] = ST_ZERO;
            end else begin
                case (state_r[i])
                    ST_ZERO:   state_next_s[i] = level[i] ? ST_SPIKE : ST_ZERO;
                    ST_SPIKE:  state_next_s[i] = level[i] ? ST_ONE : ST_ZERO;
`ifdef EDGE_EVT_FALL_EN
                    ST_ONE:    state_next_s[i] = level[i] ? ST_ONE : ST_FSPIKE;
                    ST_FSPIKE: state_next_s[i] = level[i] ? ST_SPIKE : ST_ZERO;
`else
                    ST_ONE:    state_next_s[i] = level[i] ? ST_ONE : ST_ZERO;
`endif
                    default:   state_next_s[i] = ST_ZERO;
                endcase
            end
        end
    end

    // Detector outputs, decoded from state only.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            rise_det_s[i] = (state_r[i] == ST_SPIKE);
`ifdef EDGE_EVT_FALL_EN
            fall_det_s[i] = (state_r[i] == ST_FSPIKE);
`endif
        end
    end

    // Handshake decode and the channel currently occupying the output slot.
    always_comb begin
        accept_s = evt_valid_r & evt_ready;
        for (int i = 0; i < N_CH; i++) begin
            held_s[i] = evt_valid_r && (evt_id_r == ID_W'(i));
        end
        take_s      = held_s & {N_CH{accept_s}};
        set_rise_s  = rise_det_s & ch_en;
`ifdef EDGE_EVT_FALL_EN
        take_rise_s = take_s & {N_CH{~evt_fall_r}};
        take_fall_s = take_s & {N_CH{evt_fall_r}};
        set_fall_s  = fall_det_s & ch_en;
        pend_any_s  = pend_rise_r | pend_fall_r;
`else
        take_rise_s = take_s;
        pend_any_s  = pend_rise_r;
`endif
        cand_s = pend_any_s & ch_en & ~held_s;
    end

    // A new edge coinciding with acceptance re-arms pending instead of overflowing.
    always_comb begin
        ovf_next_s       = ovf_r & ~ovf_clr;
        pend_rise_next_s = ch_en & (set_rise_s | (pend_rise_r & ~take_rise_s));
        ovf_next_s       = ovf_next_s | (set_rise_s & pend_rise_r & ~take_rise_s);
`ifdef EDGE_EVT_FALL_EN
        pend_fall_next_s = ch_en & (set_fall_s | (pend_fall_r & ~take_fall_s));
        ovf_next_s       = ovf_next_s | (set_fall_s & pend_fall_r & ~take_fall_s);
`endif
    end

    // Pending and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rise_r <= '0;
            ovf_r       <= '0;
`ifdef EDGE_EVT_FALL_EN
            pend_fall_r <= '0;
`endif
        end else begin
            pend_rise_r <= pend_rise_next_s;
            ovf_r       <= ovf_next_s;
`ifdef EDGE_EVT_FALL_EN
            pend_fall_r <= pend_fall_next_s;
`endif
        end
    end

    // Round-robin search from the pointer, first eligible channel wins.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found_s && cand_s[rr_index(rr_ptr_r, k)]) begin
                found_s  = 1'b1;
                winner_s = rr_index(rr_ptr_r, k);
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
        load_s = found_s & (~evt_valid_r | accept_s);
    end

    // One-entry output slot and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid_r <= 1'b0;
            evt_id_r    <= '0;
            rr_ptr_r    <= '0;
`ifdef EDGE_EVT_FALL_EN
            evt_fall_r  <= 1'b0;
`endif
        end else if (load_s) begin
            evt_valid_r <= 1'b1;
            evt_id_r    <= winner_s;
            rr_ptr_r    <= (winner_s == LAST_CH) ? '0 : winner_s + ID_W'(1);
`ifdef EDGE_EVT_FALL_EN
            evt_fall_r  <= ~pend_rise_r[winner_s];
`endif
        end else if (accept_s) begin
            evt_valid_r <= 1'b0;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_id    = evt_id_r;
    assign ovf       = ovf_r;
    assign pending   = pend_any_s;
`ifdef EDGE_EVT_FALL_EN
    assign evt_fall  = evt_fall_r;
`endif

endmodule
